// File: rtl/branch_resolver.sv
// Branch resolver: in-order queue of predicted branches, checked against execute results to raise flush/redirect.
// Optional statistics counters are enabled by defining BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int DEPTH        = 4,
    parameter int PC_W         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic            iPredValid,
    input  logic            iPredTake,
    input  logic [PC_W-1:0] iRecoverPC,
    input  logic            iResValid,
    input  logic            iResTaken,
    output logic            oFull,
    output logic            oEmpty,
    output logic            oBranchCmd,
    output logic            oBranchTaken,
    output logic            oFlush,
    output logic [PC_W-1:0] oRedirectPC,
    output logic [15:0]     oBranchCnt,
    output logic [15:0]     oMispredCnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [FC_W-1:0]   flushCnt_q, flushCnt_d;
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              branchCmd_q, branchCmd_d;
    logic              branchTaken_q, branchTaken_d;
    logic [PC_W-1:0]   redirectPC_q, redirectPC_d;

    logic              predMem_q [DEPTH];
    logic [PC_W-1:0]   pcMem_q   [DEPTH];

    logic              headPred;
    logic [PC_W-1:0]   headPC;
    logic              resolve;
    logic              mispredict;
    logic              push;

    assign oFull        = (count_q == CNT_FULL);
    assign oEmpty       = (count_q == '0);
    assign oBranchCmd   = branchCmd_q;
    assign oBranchTaken = branchTaken_q;
    assign oFlush       = (state_q == FLUSH);
    assign oRedirectPC  = redirectPC_q;

    assign headPred = predMem_q[rdPtr_q];
    assign headPC   = pcMem_q[rdPtr_q];

    // A mispredict blocks the same-cycle push because the queue is about to be discarded.
    always_comb begin
        resolve    = iResValid && !oEmpty && (state_q == RUN);
        mispredict = resolve && (iResTaken != headPred);
        push       = iPredValid && !oFull && (state_q == RUN) && !mispredict;
    end

    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d    = FLUSH;
                    flushCnt_d = '0;
                end
            end
            FLUSH: begin
                if (flushCnt_q == FC_LAST) begin
                    state_d    = RUN;
                    flushCnt_d = '0;
                end else begin
                    flushCnt_d = flushCnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = RUN;
                flushCnt_d = '0;
            end
        endcase
    end

    always_comb begin
        wrPtr_d       = wrPtr_q;
        rdPtr_d       = rdPtr_q;
        count_d       = count_q;
        branchCmd_d   = resolve;
        branchTaken_d = branchTaken_q;
        redirectPC_d  = redirectPC_q;
        if (resolve) begin
            branchTaken_d = iResTaken;
        end
        if (mispredict) begin
            wrPtr_d      = '0;
            rdPtr_d      = '0;
            count_d      = '0;
            redirectPC_d = headPC;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (resolve) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            case ({push, resolve})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q    <= RUN;
            flushCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            branchCmd_q   <= 1'b0;
            branchTaken_q <= 1'b0;
            redirectPC_q  <= '0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            branchCmd_q   <= branchCmd_d;
            branchTaken_q <= branchTaken_d;
            redirectPC_q  <= redirectPC_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge iClk) begin
        if (push) begin
            predMem_q[wrPtr_q] <= iPredTake;
            pcMem_q[wrPtr_q]   <= iRecoverPC;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] branchCnt_q, branchCnt_d;
    logic [15:0] mispredCnt_q, mispredCnt_d;

    always_comb begin
        branchCnt_d  = branchCnt_q;
        mispredCnt_d = mispredCnt_q;
        if (resolve && (branchCnt_q != 16'hFFFF)) begin
            branchCnt_d = branchCnt_q + 16'd1;
        end
        if (mispredict && (mispredCnt_q != 16'hFFFF)) begin
            mispredCnt_d = mispredCnt_q + 16'd1;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            branchCnt_q  <= '0;
            mispredCnt_q <= '0;
        end else begin
            branchCnt_q  <= branchCnt_d;
            mispredCnt_q <= mispredCnt_d;
        end
    end

    assign oBranchCnt  = branchCnt_q;
    assign oMispredCnt = mispredCnt_q;
`else
    assign oBranchCnt  = 16'd0;
    assign oMispredCnt = 16'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_branch_resolver;

    localparam int DEPTH        = 4;
    localparam int PC_W         = 32;
    localparam int FLUSH_CYCLES = 2;

    logic            iClk;
    logic            iRst_n;
    logic            iPredValid;
    logic            iPredTake;
    logic [PC_W-1:0] iRecoverPC;
    logic            iResValid;
    logic            iResTaken;
    logic            oFull;
    logic            oEmpty;
    logic            oBranchCmd;
    logic            oBranchTaken;
    logic            oFlush;
    logic [PC_W-1:0] oRedirectPC;
    logic [15:0]     oBranchCnt;
    logic [15:0]     oMispredCnt;

    branch_resolver #(
        .DEPTH(DEPTH),
        .PC_W(PC_W),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .iClk(iClk),
        .iRst_n(iRst_n),
        .iPredValid(iPredValid),
        .iPredTake(iPredTake),
        .iRecoverPC(iRecoverPC),
        .iResValid(iResValid),
        .iResTaken(iResTaken),
        .oFull(oFull),
        .oEmpty(oEmpty),
        .oBranchCmd(oBranchCmd),
        .oBranchTaken(oBranchTaken),
        .oFlush(oFlush),
        .oRedirectPC(oRedirectPC),
        .oBranchCnt(oBranchCnt),
        .oMispredCnt(oMispredCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic            pred;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t          mq[$];
    int              mFlushLeft;
    logic            mCmd;
    logic            mTaken;
    logic [PC_W-1:0] mRedirect;
    int              mBranchCnt;
    int              mMispCnt;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] expBranchCnt();
`ifdef BRANCH_RESOLVER_STATS_EN
        return 64'(mBranchCnt);
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] expMispCnt();
`ifdef BRANCH_RESOLVER_STATS_EN
        return 64'(mMispCnt);
`else
        return 64'd0;
`endif
    endfunction

    task automatic modelReset();
        mq.delete();
        mFlushLeft = 0;
        mCmd       = 1'b0;
        mTaken     = 1'b0;
        mRedirect  = '0;
        mBranchCnt = 0;
        mMispCnt   = 0;
    endtask

    // Advances the model by one clock using the inputs as sampled at the edge.
    task automatic modelStep();
        bit inRun;
        bit res;
        bit misp;
        bit psh;
        inRun = (mFlushLeft == 0);
        res   = iResValid && (mq.size() > 0) && inRun;
        misp  = 1'b0;
        if (res) misp = (iResTaken != mq[0].pred);
        psh   = iPredValid && (mq.size() < DEPTH) && inRun && !misp;
        if (mFlushLeft > 0) mFlushLeft--;
        mCmd = res;
        if (res) begin
            mTaken = iResTaken;
            if (mBranchCnt < 65535) mBranchCnt++;
        end
        if (misp) begin
            mRedirect  = mq[0].pc;
            mq.delete();
            mFlushLeft = FLUSH_CYCLES;
            if (mMispCnt < 65535) mMispCnt++;
        end else if (res) begin
            void'(mq.pop_front());
        end
        if (psh) mq.push_back('{pred: iPredTake, pc: iRecoverPC});
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".cmd"},   64'(oBranchCmd),  64'(mCmd));
        if (mCmd) checkOutput({tag, ".taken"}, 64'(oBranchTaken), 64'(mTaken));
        checkOutput({tag, ".flush"}, 64'(oFlush),      64'(mFlushLeft > 0));
        checkOutput({tag, ".redir"}, 64'(oRedirectPC), 64'(mRedirect));
        checkOutput({tag, ".full"},  64'(oFull),       64'(mq.size() == DEPTH));
        checkOutput({tag, ".empty"}, 64'(oEmpty),      64'(mq.size() == 0));
        checkOutput({tag, ".bcnt"},  64'(oBranchCnt),  expBranchCnt());
        checkOutput({tag, ".mcnt"},  64'(oMispredCnt), expMispCnt());
    endtask

    task automatic applyStimulus(input string tag, input logic pv, input logic pt,
                                 input logic [PC_W-1:0] pc, input logic rv, input logic rt);
        iPredValid = pv;
        iPredTake  = pt;
        iRecoverPC = pc;
        iResValid  = rv;
        iResTaken  = rt;
        @(posedge iClk);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    task automatic applyReset();
        iRst_n     = 1'b0;
        iPredValid = 1'b0;
        iPredTake  = 1'b0;
        iRecoverPC = '0;
        iResValid  = 1'b0;
        iResTaken  = 1'b0;
        #1;
        modelReset();
        checkAll("reset");
        repeat (2) @(posedge iClk);
        #1;
        iRst_n = 1'b1;
    endtask

    initial begin
        iRst_n = 1'b1;
        modelReset();
        applyReset();

        // Single correct prediction.
        applyStimulus("r27.push", 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
        applyStimulus("r27.res",  1'b0, 1'b0, 32'h0,   1'b1, 1'b1);
        checkOutput("r27.cmdK",   64'(oBranchCmd),   64'd1);
        checkOutput("r27.takenK", 64'(oBranchTaken), 64'd1);
        checkOutput("r27.flushK", 64'(oFlush),       64'd0);
        checkOutput("r27.emptyK", 64'(oEmpty),       64'd1);
        applyStimulus("r27.idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("r27.cmdOff", 64'(oBranchCmd),   64'd0);

        // Mispredict with a younger entry left behind.
        applyReset();
        applyStimulus("r28.push0", 1'b1, 1'b0, 32'h200, 1'b0, 1'b0);
        applyStimulus("r28.push1", 1'b1, 1'b1, 32'h300, 1'b0, 1'b0);
        applyStimulus("r28.res",   1'b0, 1'b0, 32'h0,   1'b1, 1'b1);
        checkOutput("r28.flushK", 64'(oFlush),      64'd1);
        checkOutput("r28.redirK", 64'(oRedirectPC), 64'h200);
        checkOutput("r28.emptyK", 64'(oEmpty),      64'd1);
        applyStimulus("r28.f2",    1'b0, 1'b0, 32'h0,   1'b1, 1'b1);
        checkOutput("r28.flush2K", 64'(oFlush),     64'd1);
        applyStimulus("r28.run",   1'b0, 1'b0, 32'h0,   1'b0, 1'b0);
        checkOutput("r28.flush3K", 64'(oFlush),     64'd0);
        checkOutput("r28.holdK",  64'(oRedirectPC), 64'h200);

        // Fill, overflow, then resolve with simultaneous pushes.
        applyReset();
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("r29.fill", 1'b1, i[0], PC_W'(32'h400 + i * 4), 1'b0, 1'b0);
        checkOutput("r29.fullK", 64'(oFull), 64'd1);
        applyStimulus("r29.over", 1'b1, 1'b0, 32'h500, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++)
            applyStimulus("r29.pp", 1'b1, 1'b1, PC_W'(32'h600 + i * 4), 1'b1, mq[0].pred);

        // Resolve on empty queue, then pushes during a flush.
        applyReset();
        applyStimulus("r30.resEmpty", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("r30.cmdK", 64'(oBranchCmd), 64'd0);
        applyStimulus("r30.push", 1'b1, 1'b1, 32'h700, 1'b0, 1'b0);
        applyStimulus("r30.misp", 1'b0, 1'b0, 32'h0,   1'b1, 1'b0);
        applyStimulus("r30.fp1",  1'b1, 1'b1, 32'h710, 1'b0, 1'b0);
        applyStimulus("r30.fp2",  1'b1, 1'b1, 32'h720, 1'b0, 1'b0);
        checkOutput("r30.emptyK", 64'(oEmpty), 64'd1);

        // Reset asserted during the first flush cycle.
        applyReset();
        applyStimulus("r31.push", 1'b1, 1'b0, 32'h800, 1'b0, 1'b0);
        applyStimulus("r31.misp", 1'b0, 1'b0, 32'h0,   1'b1, 1'b1);
        iRst_n = 1'b0;
        #1;
        checkOutput("r31.flushK", 64'(oFlush),      64'd0);
        checkOutput("r31.emptyK", 64'(oEmpty),      64'd1);
        checkOutput("r31.redirK", 64'(oRedirectPC), 64'd0);
        checkOutput("r31.bcntK",  64'(oBranchCnt),  64'd0);
        checkOutput("r31.mcntK",  64'(oMispredCnt), 64'd0);
        applyReset();
        applyStimulus("r31.post", 1'b1, 1'b1, 32'h900, 1'b0, 1'b0);

        // Randomized traffic, mostly correct predictions with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            logic rt;
            if ($urandom_range(0, 299) == 0) applyReset();
            rt = 1'($urandom_range(0, 1));
            if ((mq.size() > 0) && ($urandom_range(0, 4) != 0)) rt = mq[0].pred;
            applyStimulus("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          PC_W'($urandom), 1'($urandom_range(0, 1)), rt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
